// File: rtl/bomb_scheduler_pkg.sv
// Shared game constants: scheduler state encoding, LFSR taps and alien grid size.
`timescale 1ns/1ps
package bomb_scheduler_pkg;

    localparam int unsigned ALIEN_COLS = 11;
    localparam int unsigned LFSR_W     = 8;

    // Taps for x^8+x^6+x^5+x^4+1 in Fibonacci form: bits 7, 5, 4, 3.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COOLDOWN  = 3'd1,
        PICK_COL  = 3'd2,
        PICK_SLOT = 3'd3,
        FIRE      = 3'd4
    } state_t;

endpackage

// File: rtl/bomb_scheduler_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; shifts feedback into bit 0 every cycle.
`timescale 1ns/1ps
module lfsr8
    import bomb_scheduler_pkg::*;
(
    input  logic              s_clk,
    input  logic              reset,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic feedback;

    assign feedback = ^(q & LFSR_TAPS);

    always_ff @(posedge s_clk) begin
        if (reset) begin
            q <= seed;
        end else begin
            q <= {q[LFSR_W-2:0], feedback};
        end
    end

endmodule

// File: rtl/bomb_scheduler.sv
// Alien bomb scheduler: cooldown in frames, random column scan, round-robin slot launch.
`timescale 1ns/1ps
module bomb_scheduler
    import bomb_scheduler_pkg::*;
#(
    parameter int unsigned NUM_SLOTS       = 3,
    parameter int unsigned NUM_COLS        = ALIEN_COLS,
    parameter int unsigned COOLDOWN_FRAMES = 40,
    parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
    input  logic                 s_clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 game_run,
    input  logic [NUM_COLS-1:0]  col_alive,
    input  logic [NUM_SLOTS-1:0] slot_active,
    output logic [NUM_SLOTS-1:0] fire,
    output logic [3:0]           fire_col,
    output logic                 busy,
    output logic [7:0]           fire_count
);

    localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned CD_W   = 6;
    localparam int unsigned COL_W  = 4;

    localparam logic [CD_W-1:0]   CD_RELOAD = CD_W'(COOLDOWN_FRAMES);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(NUM_COLS - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    state_t              state, state_d;
    logic [CD_W-1:0]     cd_cnt, cd_d;
    logic [COL_W-1:0]    scan_idx, idx_d;
    logic [COL_W-1:0]    scan_cnt, scnt_d;
    logic [COL_W-1:0]    sel_col, sel_col_d;
    logic [SLOT_W-1:0]   sel_slot, sel_slot_d;
    logic [SLOT_W-1:0]   rr_ptr, rr_d;
    logic [7:0]          count_d;
    logic [NUM_SLOTS-1:0] fire_d;
    logic [3:0]          fire_col_d;
    logic                busy_d;

    logic [7:0]          lfsr_q;
    logic [COL_W-1:0]    entry_idx;
    logic                slot_found;
    logic [SLOT_W-1:0]   free_slot;
    logic                unused_lfsr_hi;

    lfsr8 u_lfsr (
        .s_clk (s_clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // Only the low nibble seeds the column scan.
    assign unused_lfsr_hi = ^lfsr_q[7:4];
    assign entry_idx = (int'(lfsr_q[3:0]) < int'(NUM_COLS)) ? lfsr_q[3:0]
                     : COL_W'(int'(lfsr_q[3:0]) - int'(NUM_COLS));

    // First free slot, searching round-robin from rr_ptr.
    always_comb begin
        int unsigned cand;
        slot_found = 1'b0;
        free_slot  = '0;
        cand       = 0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_SLOTS) begin
                cand = cand - NUM_SLOTS;
            end
            if (!slot_found && !slot_active[SLOT_W'(cand)]) begin
                slot_found = 1'b1;
                free_slot  = SLOT_W'(cand);
            end
        end
    end

    always_comb begin
        state_d    = state;
        cd_d       = cd_cnt;
        idx_d      = scan_idx;
        scnt_d     = scan_cnt;
        sel_col_d  = sel_col;
        sel_slot_d = sel_slot;
        rr_d       = rr_ptr;
        count_d    = fire_count;
        fire_d     = '0;
        fire_col_d = '0;

        case (state)
            IDLE: begin
                if (game_run) begin
                    cd_d    = CD_RELOAD;
                    state_d = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (frame_tick) begin
                    if (cd_cnt <= CD_W'(1)) begin
                        cd_d    = '0;
                        idx_d   = entry_idx;
                        scnt_d  = '0;
                        state_d = PICK_COL;
                    end else begin
                        cd_d = cd_cnt - CD_W'(1);
                    end
                end
            end
            PICK_COL: begin
                if (col_alive[scan_idx]) begin
                    sel_col_d = scan_idx;
                    state_d   = PICK_SLOT;
                end else if (scan_cnt == LAST_COL) begin
                    cd_d    = CD_RELOAD;
                    state_d = COOLDOWN;
                end else begin
                    idx_d  = (scan_idx == LAST_COL) ? '0 : scan_idx + COL_W'(1);
                    scnt_d = scan_cnt + COL_W'(1);
                end
            end
            PICK_SLOT: begin
                if (slot_found) begin
                    sel_slot_d        = free_slot;
                    fire_d[free_slot] = 1'b1;
                    fire_col_d        = sel_col;
                    state_d           = FIRE;
                end else begin
                    cd_d    = CD_RELOAD;
                    state_d = COOLDOWN;
                end
            end
            FIRE: begin
                count_d = fire_count + 8'd1;
                rr_d    = (sel_slot == LAST_SLOT) ? '0 : sel_slot + SLOT_W'(1);
                cd_d    = CD_RELOAD;
                state_d = COOLDOWN;
            end
            default: state_d = IDLE;
        endcase

        // Stopping the game wins over every transition; a launch already in FIRE still counts.
        if (!game_run) begin
            state_d    = IDLE;
            fire_d     = '0;
            fire_col_d = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge s_clk) begin
        if (reset) begin
            state      <= IDLE;
            cd_cnt     <= '0;
            scan_idx   <= '0;
            scan_cnt   <= '0;
            sel_col    <= '0;
            sel_slot   <= '0;
            rr_ptr     <= '0;
            fire_count <= '0;
            fire       <= '0;
            fire_col   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cd_cnt     <= cd_d;
            scan_idx   <= idx_d;
            scan_cnt   <= scnt_d;
            sel_col    <= sel_col_d;
            sel_slot   <= sel_slot_d;
            rr_ptr     <= rr_d;
            fire_count <= count_d;
            fire       <= fire_d;
            fire_col   <= fire_col_d;
            busy       <= busy_d;
        end
    end

endmodule
